// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, checks framing and odd parity,
// and strips the E0/F0 prefixes so that only make codes, releases and errors reach the outputs.
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d;
  logic          valid_q, valid_d, rel_q, rel_d, err_q, err_d;
  logic          strobe_s, accept_s;

  // Glitch filter: the filtered clock follows only a level held for FILTER_LEN cycles.
  always_comb begin
    clk_f_d    = clk_f_q;
    filt_cnt_d = '0;
    if (clk_s2_q != clk_f_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  assign strobe_s = clk_f_q & ~clk_f_d;

  // Frame FSM, timeout supervision and the E0/F0 prefix layer.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    key_code_d = key_code_q;
    key_ext_d  = key_ext_q;
    valid_d    = 1'b0;
    rel_d      = 1'b0;
    err_d      = 1'b0;
    accept_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (strobe_s && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (strobe_s) begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = (bit_cnt_q == 4'd7) ? S_PARITY : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (strobe_s) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (strobe_s) begin
          state_d = S_IDLE;
          if ((^{shreg_q, par_q}) && dat_s2_q) begin
            accept_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe always reloads the counter, so it beats a coincident terminal count.
    if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (strobe_s) begin
      tmo_d = '0;
    end else if (tmo_q >= TW'(TIMEOUT_CYC - 1)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (accept_s) begin
      if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        rel_d = 1'b1;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        key_code_d = shreg_q;
        key_ext_d  = ext_q;
        valid_d    = 1'b1;
        ext_d      = 1'b0;
      end
    end else begin
      key_code_d = key_code_q;
    end
  end

  // State and output registers; the line synchronizers idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_f_q    <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      key_code_q <= 8'h00;
      key_ext_q  <= 1'b0;
      valid_q    <= 1'b0;
      rel_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      clk_f_q    <= clk_f_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      key_code_q <= key_code_d;
      key_ext_q  <= key_ext_d;
      valid_q    <= valid_d;
      rel_q      <= rel_d;
      err_q      <= err_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_valid   = valid_q;
  assign key_release = rel_q;
  assign frame_err   = err_q;

endmodule
